// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative MULT/DIV into HI/LO,
// with a start/busy/done handshake so the control unit can stall on long ops.
module alu_mc #(
  parameter int WIDTH     = 32,
  parameter int LUI_SHIFT = WIDTH / 2,
  parameter int INC_CONST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [1:0]       sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC_CONST);
  localparam logic [SHW:0]     CNT_END = (SHW + 1)'(WIDTH);
  localparam logic [SHW:0]     CNT_ONE = (SHW + 1)'(1);

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_MULT = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;
  localparam logic [3:0] OP_INC  = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                 state, state_nx;
  logic [SHW:0]           cnt;
  logic [2*WIDTH-1:0]     acc;
  logic [WIDTH-1:0]       opnd;
  logic                   neg_q, neg_r, b_zero;
  logic                   accept;

  logic [WIDTH-1:0]        b_op, y_nx, div_diff;
  logic [WIDTH:0]          sum, mul_upper, div_shift;
  logic signed [WIDTH-1:0] b_s;
  logic [SHW-1:0]          shamt;
  logic [3:0]              flags_nx;
  logic                    div_ge;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic signed_mode);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (signed_mode && (sv < 0)) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
    return neg ? -v : v;
  endfunction

  assign busy   = (state == MUL) || (state == DIV);
  assign accept = start && !busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start && operation == OP_MULT)     state_nx = MUL;
        else if (start && operation == OP_DIV) state_nx = DIV;
      end
      MUL, DIV: if (cnt == CNT_END) state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
  end

  // Single-cycle result and flags, captured only on an accept edge
  always_comb begin
    b_op     = sign[0] ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sign[0]};
    b_s      = b;
    shamt    = a[SHW-1:0];
    y_nx     = y;
    flags_nx = flags;
    case (operation)
      OP_PASS: y_nx = b;
      OP_ADD: begin
        y_nx        = sum[WIDTH-1:0];
        flags_nx[3] = sum[WIDTH];
        flags_nx[2] = (sum[WIDTH-1:0] == '0);
        flags_nx[1] = sum[WIDTH-1];
        flags_nx[0] = sign[1] && (a[WIDTH-1] == b_op[WIDTH-1]) &&
                      (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  y_nx = a & b;
      OP_OR:   y_nx = a | b;
      OP_NOR:  y_nx = ~(a | b);
      OP_SRL:  y_nx = b >> shamt;
      OP_SLL:  y_nx = b << shamt;
      OP_SRA:  y_nx = b_s >>> shamt;
      OP_LUI:  y_nx = a << LUI_SHIFT;
      OP_INC:  y_nx = b + INC_W;
      OP_XOR:  y_nx = a ^ b;
      default: ;
    endcase
  end

  // One shift-add or restoring-subtract step; both share acc = {upper, lower}
  always_comb begin
    mul_upper = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y        <= '0;
      hi       <= '0;
      lo       <= '0;
      flags    <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt <= '0;
        case (operation)
          OP_MULT: begin
            acc   <= {{WIDTH{1'b0}}, magnitude(b, sign[1])};
            opnd  <= magnitude(a, sign[1]);
            neg_q <= sign[1] && (a[WIDTH-1] ^ b[WIDTH-1]);
          end
          OP_DIV: begin
            acc    <= {{WIDTH{1'b0}}, magnitude(a, sign[1])};
            opnd   <= magnitude(b, sign[1]);
            neg_q  <= sign[1] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sign[1] && a[WIDTH-1];
            b_zero <= (b == '0);
          end
          default: begin
            y     <= y_nx;
            flags <= flags_nx;
            done  <= 1'b1;
          end
        endcase
      end else if (busy) begin
        if (cnt != CNT_END) begin
          cnt <= cnt + CNT_ONE;
          acc <= (state == MUL) ? {mul_upper, acc[WIDTH-1:1]}
                                : {div_ge ? div_diff : div_shift[WIDTH-1:0],
                                   acc[WIDTH-2:0], div_ge};
        end else begin
          // With a zero divisor the remainder path already reproduces a
          done <= 1'b1;
          if (state == MUL) begin
            {hi, lo} <= cond_neg_2w(acc, neg_q);
          end else begin
            hi       <= cond_neg_w(acc[2*WIDTH-1:WIDTH], neg_r);
            lo       <= b_zero ? '1 : cond_neg_w(acc[WIDTH-1:0], neg_q);
            div_zero <= b_zero;
          end
        end
      end
    end
  end

endmodule
